// File: rtl/eds_frame_pkg.sv
// Shared types and constants for the EDS frame sequencer.
package eds_frame_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

  // Default unit length: 1 ms at 100 MHz.
  localparam int unsigned UNIT_MS = 100000;

  // Prescaler width for a given unit length (never narrower than one bit).
  function automatic int unsigned presc_width(input int unsigned cycles);
    if (cycles < 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(cycles);
    end
  endfunction

  localparam int unsigned UNIT_MS_W = presc_width(UNIT_MS);

endpackage

// File: rtl/eds_unit_tick.sv
// Unit-tick prescaler: counts clock cycles and pulses tick once per unit.
// The clear input restarts the unit so every HOLD/GAP entry starts aligned.
module eds_unit_tick
  import eds_frame_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = UNIT_MS
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  output logic tick
);

  localparam int unsigned PW = presc_width(UNIT_CYCLES);
  localparam logic [PW-1:0] PRESC_LAST = PW'(UNIT_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_ZERO = {PW{1'b0}};
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

  logic [PW-1:0] presc_r;

  // Prescaler: cleared on request, wraps to zero after the last cycle of a unit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_r <= PRESC_ZERO;
    end else if (clr) begin
      presc_r <= PRESC_ZERO;
    end else if (presc_r == PRESC_LAST) begin
      presc_r <= PRESC_ZERO;
    end else begin
      presc_r <= presc_r + PRESC_ONE;
    end
  end

  assign tick = (presc_r == PRESC_LAST);

endmodule

// File: rtl/eds_frame_seq.sv
// EDS frame sequencer: edge-triggered, programmable hold/gap/repeat
// frame-enable generator with abort and status outputs.
module eds_frame_seq
  import eds_frame_pkg::*;
#(
  parameter int unsigned CH_NUM      = 3,
  parameter int unsigned UNIT_CYCLES = UNIT_MS,
  parameter int unsigned HOLD_W      = 32,
  parameter int unsigned REP_W       = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              eds_frame_en_i,
  input  logic [CH_NUM-1:0] eds_frame_sel_i,
  input  logic [HOLD_W-1:0] eds_frame_hold_i,
  input  logic [HOLD_W-1:0] eds_frame_gap_i,
  input  logic [REP_W-1:0]  eds_frame_rep_i,
  input  logic              eds_abort_i,
  output logic [CH_NUM-1:0] eds_frame_sel_o,
  output logic              eds_frame_en_o,
  output logic              eds_frame_busy_o,
  output logic              eds_frame_done_o,
  output logic [REP_W-1:0]  eds_frame_cnt_o
);

  localparam logic [HOLD_W-1:0] HOLD_ZERO = {HOLD_W{1'b0}};
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [REP_W-1:0]  REP_ZERO  = {REP_W{1'b0}};
  localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);
  localparam logic [CH_NUM-1:0] SEL_ZERO  = {CH_NUM{1'b0}};

  state_t            state_r;
  logic              en_d_r;
  logic              arm_r;
  logic [HOLD_W-1:0] hold_r;
  logic [HOLD_W-1:0] gap_r;
  logic [REP_W-1:0]  rep_r;
  logic [HOLD_W-1:0] unit_r;

  logic              tick_s;
  logic              clr_s;
  logic              start_s;
  logic              accept_s;
  logic              hold_last_s;
  logic              gap_last_s;
  logic              last_frame_s;
  logic [REP_W-1:0]  cnt_inc_s;

  // arm_r blocks a level that was already high across reset from starting a run.
  assign start_s  = eds_frame_en_i & ~en_d_r & arm_r;
  assign accept_s = start_s & (|eds_frame_sel_i) & (eds_frame_hold_i != HOLD_ZERO)
                    & ~eds_abort_i;

  assign cnt_inc_s    = eds_frame_cnt_o + REP_ONE;
  assign hold_last_s  = tick_s & (unit_r == (hold_r - HOLD_ONE));
  // A zero gap still yields one low cycle: GAP is left on its first cycle.
  assign gap_last_s   = (gap_r == HOLD_ZERO) | (tick_s & (unit_r == (gap_r - HOLD_ONE)));
  assign last_frame_s = (rep_r != REP_ZERO) & (cnt_inc_s == rep_r);

  // Prescaler clear: held in IDLE, pulsed on every HOLD/GAP exit so each entry starts at zero.
  always_comb begin
    clr_s = 1'b1;
    case (state_r)
      IDLE:    clr_s = 1'b1;
      HOLD:    clr_s = eds_abort_i | hold_last_s;
      GAP:     clr_s = eds_abort_i | gap_last_s;
      default: clr_s = 1'b1;
    endcase
  end

  eds_unit_tick #(
    .UNIT_CYCLES(UNIT_CYCLES)
  ) u_tick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (clr_s),
    .tick  (tick_s)
  );

  // Sequencer FSM with registered outputs, start-edge register and programming latches.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r          <= IDLE;
      en_d_r           <= 1'b0;
      arm_r            <= ~eds_frame_en_i;
      hold_r           <= HOLD_ZERO;
      gap_r            <= HOLD_ZERO;
      rep_r            <= REP_ZERO;
      unit_r           <= HOLD_ZERO;
      eds_frame_sel_o  <= SEL_ZERO;
      eds_frame_en_o   <= 1'b0;
      eds_frame_busy_o <= 1'b0;
      eds_frame_done_o <= 1'b0;
      eds_frame_cnt_o  <= REP_ZERO;
    end else begin
      en_d_r           <= eds_frame_en_i;
      arm_r            <= arm_r | ~eds_frame_en_i;
      eds_frame_done_o <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            eds_frame_sel_o  <= eds_frame_sel_i;
            hold_r           <= eds_frame_hold_i;
            gap_r            <= eds_frame_gap_i;
            rep_r            <= eds_frame_rep_i;
            unit_r           <= HOLD_ZERO;
            eds_frame_cnt_o  <= REP_ZERO;
            eds_frame_en_o   <= 1'b1;
            eds_frame_busy_o <= 1'b1;
            state_r          <= HOLD;
          end else begin
            eds_frame_en_o   <= 1'b0;
            eds_frame_busy_o <= 1'b0;
          end
        end
        HOLD: begin
          if (eds_abort_i) begin
            eds_frame_en_o   <= 1'b0;
            eds_frame_busy_o <= 1'b0;
            state_r          <= IDLE;
          end else if (hold_last_s) begin
            eds_frame_cnt_o <= cnt_inc_s;
            eds_frame_en_o  <= 1'b0;
            unit_r          <= HOLD_ZERO;
            if (last_frame_s) begin
              eds_frame_busy_o <= 1'b0;
              eds_frame_done_o <= 1'b1;
              state_r          <= IDLE;
            end else begin
              state_r <= GAP;
            end
          end else if (tick_s) begin
            unit_r <= unit_r + HOLD_ONE;
          end else begin
            unit_r <= unit_r;
          end
        end
        GAP: begin
          if (eds_abort_i) begin
            eds_frame_busy_o <= 1'b0;
            state_r          <= IDLE;
          end else if (gap_last_s) begin
            eds_frame_en_o <= 1'b1;
            unit_r         <= HOLD_ZERO;
            state_r        <= HOLD;
          end else if (tick_s) begin
            unit_r <= unit_r + HOLD_ONE;
          end else begin
            unit_r <= unit_r;
          end
        end
        default: begin
          eds_frame_en_o   <= 1'b0;
          eds_frame_busy_o <= 1'b0;
          state_r          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eds_frame_seq.sv
// Directed self-checking bench for eds_frame_seq with a 10-cycle unit.
module tb_eds_frame_seq;

  localparam int CH_NUM = 3;
  localparam int UNIT   = 10;
  localparam int HOLD_W = 32;
  localparam int REP_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [CH_NUM-1:0] sel;
  logic [HOLD_W-1:0] hold;
  logic [HOLD_W-1:0] gap;
  logic [REP_W-1:0]  rep;
  logic              abort;
  logic [CH_NUM-1:0] sel_o;
  logic              en_o;
  logic              busy_o;
  logic              done_o;
  logic [REP_W-1:0]  cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n;
  int dn;

  always #5 clk = ~clk;

  eds_frame_seq #(
    .CH_NUM(CH_NUM), .UNIT_CYCLES(UNIT), .HOLD_W(HOLD_W), .REP_W(REP_W)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .eds_frame_en_i(en), .eds_frame_sel_i(sel),
    .eds_frame_hold_i(hold), .eds_frame_gap_i(gap),
    .eds_frame_rep_i(rep), .eds_abort_i(abort),
    .eds_frame_sel_o(sel_o), .eds_frame_en_o(en_o),
    .eds_frame_busy_o(busy_o), .eds_frame_done_o(done_o),
    .eds_frame_cnt_o(cnt_o)
  );

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Low then high on en: the cycle after return shows the first HOLD cycle.
  task automatic start_run();
    en = 1'b0;
    step(1);
    en = 1'b1;
    step(1);
  endtask

  // Count consecutive sampled cycles with en_o high (bounded).
  task automatic run_high(output int cnt);
    cnt = 0;
    while (en_o === 1'b1 && cnt < 2000) begin
      cnt++;
      step(1);
    end
  endtask

  // Count consecutive GAP cycles (en_o low, busy high), tallying done pulses.
  task automatic run_low(output int cnt, output int dones);
    cnt = 0;
    dones = 0;
    while (en_o === 1'b0 && busy_o === 1'b1 && cnt < 2000) begin
      if (done_o === 1'b1) dones++;
      cnt++;
      step(1);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; abort = 1'b0;
    sel = 3'b000; hold = 32'd0; gap = 32'd0; rep = 16'd0;
    step(3);
    chk("reset_en", en_o, 32'd0);
    chk("reset_busy", busy_o, 32'd0);
    chk("reset_done", done_o, 32'd0);
    chk("reset_sel", sel_o, 32'd0);
    chk("reset_cnt", cnt_o, 32'd0);
    rst = 1'b0;
    step(2);

    // Single frame: 30 high cycles then one done pulse.
    sel = 3'b101; hold = 32'd3; gap = 32'd0; rep = 16'd1;
    start_run();
    chk("t1_busy_start", busy_o, 32'd1);
    run_high(n);
    chk("t1_high_len", n, 32'd30);
    chk("t1_done", done_o, 32'd1);
    chk("t1_busy_end", busy_o, 32'd0);
    chk("t1_sel", sel_o, 32'd5);
    chk("t1_cnt", cnt_o, 32'd1);
    step(1);
    chk("t1_done_once", done_o, 32'd0);

    // en held high after done: no restart.
    step(5);
    chk("hold_high_no_restart", busy_o, 32'd0);

    // Repeat: 3 x 20 high, 10 low between.
    sel = 3'b011; hold = 32'd2; gap = 32'd1; rep = 16'd3;
    start_run();
    chk("t2_cnt_cleared", cnt_o, 32'd0);
    chk("t2_sel", sel_o, 32'd3);
    for (int f = 0; f < 2; f++) begin
      run_high(n);
      chk("t2_high_len", n, 32'd20);
      run_low(n, dn);
      chk("t2_gap_len", n, 32'd10);
      chk("t2_gap_no_done", dn, 32'd0);
    end
    run_high(n);
    chk("t2_high_last", n, 32'd20);
    chk("t2_done", done_o, 32'd1);
    chk("t2_cnt", cnt_o, 32'd3);

    // Zero gap: 10 high, 1 low, 10 high, done.
    sel = 3'b001; hold = 32'd1; gap = 32'd0; rep = 16'd2;
    start_run();
    run_high(n);
    chk("t3_high1", n, 32'd10);
    run_low(n, dn);
    chk("t3_gap_one", n, 32'd1);
    run_high(n);
    chk("t3_high2", n, 32'd10);
    chk("t3_done", done_o, 32'd1);
    chk("t3_cnt", cnt_o, 32'd2);

    // Continuous with abort in frame 5.
    sel = 3'b110; hold = 32'd1; gap = 32'd1; rep = 16'd0;
    start_run();
    for (int f = 0; f < 4; f++) begin
      run_high(n);
      chk("t4_high", n, 32'd10);
      run_low(n, dn);
      chk("t4_gap", n, 32'd10);
    end
    chk("t4_cnt_before", cnt_o, 32'd4);
    step(4);
    abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("t4_abort_en", en_o, 32'd0);
    chk("t4_abort_busy", busy_o, 32'd0);
    chk("t4_abort_done", done_o, 32'd0);
    chk("t4_abort_cnt", cnt_o, 32'd4);
    chk("t4_abort_sel", sel_o, 32'd6);
    step(1);
    chk("t4_no_late_done", done_o, 32'd0);

    // Rejected starts.
    sel = 3'b000; hold = 32'd1; rep = 16'd1;
    start_run();
    step(2);
    chk("rej_sel0", busy_o | en_o, 32'd0);
    sel = 3'b010; hold = 32'd0;
    start_run();
    step(2);
    chk("rej_hold0", busy_o | en_o, 32'd0);
    hold = 32'd1;
    en = 1'b0;
    step(1);
    en = 1'b1; abort = 1'b1;
    step(1);
    abort = 1'b0;
    chk("rej_abort_start", busy_o, 32'd0);
    step(3);
    chk("rej_abort_later", busy_o, 32'd0);
    chk("rej_sel_unlatched", sel_o, 32'd6);

    // Restart after toggle.
    start_run();
    chk("restart_en", en_o, 32'd1);
    run_high(n);
    chk("restart_len", n, 32'd10);
    chk("restart_done", done_o, 32'd1);

    // Reset mid-HOLD with en held high.
    sel = 3'b111; hold = 32'd3; rep = 16'd1;
    start_run();
    step(5);
    rst = 1'b1;
    step(1);
    chk("rst_en", en_o, 32'd0);
    chk("rst_busy", busy_o, 32'd0);
    chk("rst_sel", sel_o, 32'd0);
    chk("rst_cnt", cnt_o, 32'd0);
    rst = 1'b0;
    step(5);
    chk("rst_no_level_start", busy_o | en_o, 32'd0);
    start_run();
    chk("rst_restart_en", en_o, 32'd1);
    run_high(n);
    chk("rst_restart_len", n, 32'd30);
    chk("rst_restart_cnt", cnt_o, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/eds_frame_seq.md
Name: eds_frame_seq

Overview:
Parametrised successor to the single-shot EDS frame-enable generator. It drives a CH_NUM-wide PMT select and a frame-enable level for a programmable number of frames. Each frame has a programmable hold time and a programmable gap, both counted in unit ticks. Start is edge-triggered, abort is supported, and status (busy, done, frame count) is exported. It sits between the register/command decoder and the PMT scan-start outputs.

Parameters:
CH_NUM, 3, number of PMT select bits (bit[0] pmt1, bit[1] pmt2, ...)
UNIT_CYCLES, 100000, clk_i cycles per unit tick (1 ms at 100 MHz); must be >= 2
HOLD_W, 32, width of hold and gap programming
REP_W, 16, width of frame-repeat programming and frame counter

Ports:
clk_i  in  1  single clock
rst_i  in  1  synchronous reset, active-high
eds_frame_en_i  in  1  start request; rising edge is the trigger
eds_frame_sel_i  in  CH_NUM  PMT select, latched at start
eds_frame_hold_i  in  HOLD_W  frame-enable high time, in units
eds_frame_gap_i  in  HOLD_W  low time between frames, in units
eds_frame_rep_i  in  REP_W  number of frames; 0 = continuous until abort
eds_abort_i  in  1  abort; level, sampled each cycle
eds_frame_sel_o  out  CH_NUM  latched select
eds_frame_en_o  out  1  frame enable (scan start)
eds_frame_busy_o  out  1  high from the start cycle until return to IDLE
eds_frame_done_o  out  1  one-cycle pulse on normal completion
eds_frame_cnt_o  out  REP_W  completed frames in the current run

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: all outputs 0, state IDLE, edge register 0, all counters 0.
- Start edge detection: en_d registers eds_frame_en_i. start = en_i & ~en_d.
- Start qualification: start is accepted only in IDLE, with |sel_i != 0, hold_i != 0 and eds_abort_i == 0. Otherwise it is ignored and there is no latched state.
- While eds_frame_en_i stays high, no re-trigger occurs. It must go low and then high again.
- On an accepted start, sample at edge k:
  - sel, hold, gap and rep are latched.
  - cnt_o is cleared.
  - From cycle k+1: en_o=1, busy_o=1, state HOLD.
  - Inputs are not re-sampled until the next start.
- Unit tick: a prescaler runs only in HOLD and GAP.
  - It is cleared on every state entry.
  - tick fires when the prescaler equals UNIT_CYCLES-1, then the prescaler wraps to 0.
  - Prescaler width is $clog2(UNIT_CYCLES).
- HOLD state:
  - en_o stays high for exactly hold*UNIT_CYCLES cycles.
  - On the final tick, cnt_o increments (wraps modulo 2^REP_W).
  - If rep != 0 and the incremented count equals rep, go to IDLE.
  - Otherwise go to GAP.
- Normal completion: on the first cycle with en_o=0, done_o=1 for one cycle and busy_o=0. sel_o and cnt_o hold their values.
- GAP state:
  - en_o=0 for gap*UNIT_CYCLES cycles, then HOLD is re-entered.
  - gap==0 still forces exactly one low cycle, so downstream always sees an edge.
- Abort (eds_abort_i=1 in HOLD or GAP):
  - Next cycle: IDLE, en_o=0, busy_o=0, no done pulse.
  - cnt_o keeps the frames completed so far. sel_o holds.
- Simultaneous events:
  - Abort and start in IDLE: abort wins.
  - Abort on the final tick: abort wins, so there is no done pulse and no cnt increment.
- Reset mid-operation: outputs return to their reset values on the next cycle. A start edge must be seen again after reset is released; a level already high does not start.
- Continuous mode (rep=0): HOLD/GAP alternates indefinitely. cnt_o wraps.

Decomposition:
- Package eds_frame_pkg holds:
  - the state enum {IDLE, HOLD, GAP};
  - the UNIT_MS default constant (100000);
  - the helper localparam for prescaler width.
- Sub-module eds_unit_tick: a prescaler with a clear input and a tick output, parameter UNIT_CYCLES. It is reused for the hold and gap timing.

Test Plan (UNIT_CYCLES=10 for sim):
- Single frame: sel=3'b101, hold=3, rep=1, en_i rising -> en_o high exactly 30 cycles starting 1 cycle after the edge; done_o one pulse at the first low cycle; sel_o=101; cnt_o=1; busy_o low after.
- Repeat: hold=2, gap=1, rep=3 -> three 20-cycle high pulses separated by 10-cycle lows; one done pulse after the third; cnt_o=3.
- Zero gap: gap=0, hold=1, rep=2 -> 10 high, 1 low, 10 high, then done.
- Continuous and abort: rep=0, hold=1, gap=1; assert abort mid-HOLD of frame 5 -> en_o=0 and busy_o=0 the next cycle, no done pulse, cnt_o=4.
- Rejected starts and edge rule:
  - sel=0 with en_i edge -> no activity.
  - hold=0 -> no activity.
  - en_i held high after done -> no restart.
  - en_i low then high -> restart.
  - abort and start in the same cycle -> ignored.
- Reset mid-HOLD with en_i still high -> all outputs 0 the next cycle; no restart until en_i toggles.
